// File: rtl/mips_timer_pkg.sv
// Shared definitions for the bridge-mapped countdown timer: register map,
// CTRL field positions, MODE encodings and FSM states.
package mips_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IM = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  // MODE 2/3 fall back to one-shot, so only the exact reload code reloads.
  function automatic logic is_reload(input logic [3:0] ctrl);
    return ctrl[2:1] == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/mips_timer_prescaler.sv
// Divides the clock into a one-cycle tick every PRESCALE cycles; clr restarts
// the division so the first tick lands a full period after clr drops.
module timer_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == W'(PRESCALE - 1));
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mips_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) driving the core's HWInt.
// Define TIMER_PRESCALE_EN to count only on prescaler ticks.
module mips_timer
  import mips_timer_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  state_t      state_q, state_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic        wr_ctrl, wr_preset;

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q == ST_IDLE) || (state_q == ST_LOAD)),
    .tick  (tick)
  );
`else
  // Every cycle is a tick; PRESCALE is legal only when >= 1.
  assign tick = (PRESCALE > 0);
`endif

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      ST_IDLE: if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count_q <= 32'd1) begin
            count_d    = '0;
            irq_flag_d = 1'b1;
            state_d    = ST_INT;
          end else begin
            count_d = count_q - 32'd1;
          end
        end
      end
      ST_INT: begin
        if (is_reload(ctrl_q)) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Software writes override the hardware updates above.
    if (wr_ctrl)   ctrl_d   = din[3:0];
    if (wr_preset) preset_d = din;
    if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;
    if ((state_q == ST_INT) && !ctrl_d[CTRL_EN]) state_d = ST_IDLE;

    irq_d = ctrl_d[CTRL_IM] & irq_flag_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    case (addr)
      ADDR_CTRL:   dout = {28'd0, ctrl_q};
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer: register-access vector table plus cycle-exact
// sequences for one-shot, auto-reload, disable, masking, reset and prescale.
module tb_mips_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int total = 0;
  int bad = 0;

  mips_timer #(.PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we    = 1'b0;
    tick_n(2);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, dout, exp);
  endtask

  int pulses;

  initial begin
    vecs[0] = '{1'b1, 2'd1, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 32'h0000_FFFF, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 2'd3, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, 2'd0, 32'hFFFF_FFF6, 32'h0000_0006, 1'b0};
    vecs[4] = '{1'b0, 2'd1, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[5] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0000_0000, 1'b0};

    // Reset state, idle for 20 cycles.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      addr = 2'(k % 4);
      #1;
      chk($sformatf("reset_dout_a%0d", k % 4), dout, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      tick_n(1);
    end

    // Register-access table.
    for (int i = 0; i < 6; i++) begin
      addr = vecs[i].addr;
      din  = vecs[i].din;
      we   = vecs[i].we;
      @(posedge clk);
      #1;
      we = 1'b0;
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end

    // One-shot: PRESET=5, irq rises on edge 7.
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      tick_n(1);
      chk($sformatf("oneshot_irq_e%0d", k), {31'd0, irq}, {31'd0, (k == 7)});
    end
    rd("oneshot_count", 2'd2, 32'd0);
    tick_n(1);
    rd("oneshot_ctrl", 2'd0, 32'h8);
    chk("oneshot_irq_held", {31'd0, irq}, 32'd1);
    tick_n(5);
    chk("oneshot_irq_held5", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'd5);
    chk("oneshot_irq_clr", {31'd0, irq}, 32'd0);
    tick_n(10);
    chk("oneshot_stay_idle", {31'd0, irq}, 32'd0);

    // PRESET=0 acts as 1; MODE=2 acts as one-shot; rewrite in INT keeps EN.
    do_reset();
    wr(2'd0, 32'hD);
    for (int k = 1; k <= 3; k++) begin
      tick_n(1);
      chk($sformatf("p0_irq_e%0d", k), {31'd0, irq}, {31'd0, (k == 3)});
    end
    wr(2'd0, 32'hD);
    chk("rewrite_irq_clr", {31'd0, irq}, 32'd0);
    rd("rewrite_ctrl", 2'd0, 32'hD);
    for (int k = 1; k <= 3; k++) begin
      tick_n(1);
      chk($sformatf("rewrite_irq_e%0d", k), {31'd0, irq}, {31'd0, (k == 3)});
    end
    tick_n(1);
    rd("mode2_ctrl", 2'd0, 32'hC);

    // Auto-reload: PRESET=3 -> pulse every 5 cycles.
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick_n(1);
      if (irq) pulses++;
      chk($sformatf("reload_irq_e%0d", k), {31'd0, irq}, {31'd0, (k % 5 == 0)});
    end
    chk("reload_pulses", pulses, 32'd4);
    wr(2'd0, 32'h8);
    chk("reload_stop_irq", {31'd0, irq}, 32'd0);
    tick_n(10);
    chk("reload_stopped_irq", {31'd0, irq}, 32'd0);
    rd("reload_stop_ctrl", 2'd0, 32'h8);
    rd("reload_stop_count", 2'd2, 32'd0);

    // Disable mid-count: COUNT freezes at 92.
    do_reset();
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    tick_n(9);
    wr(2'd0, 32'h8);
    tick_n(5);
    rd("disable_count", 2'd2, 32'd92);
    pulses = 0;
    for (int k = 0; k < 120; k++) begin
      tick_n(1);
      if (irq) pulses++;
    end
    chk("disable_no_irq", pulses, 32'd0);
    rd("disable_count_late", 2'd2, 32'd92);

    // IM=0 masks irq; reset mid-count clears everything.
    do_reset();
    wr(2'd0, 32'h1);
    wr(2'd1, 32'd2);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick_n(1);
      if (irq) pulses++;
    end
    chk("masked_no_irq", pulses, 32'd0);
    wr(2'd1, 32'd1000);
    wr(2'd0, 32'h9);
    tick_n(10);
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0;
    chk("midreset_irq", {31'd0, irq}, 32'd0);
    rd("midreset_ctrl", 2'd0, 32'd0);
    rd("midreset_preset", 2'd1, 32'd0);
    rd("midreset_count", 2'd2, 32'd0);
    tick_n(1);
    rd("midreset_addr3", 2'd3, 32'd0);

`ifdef TIMER_PRESCALE_EN
    // Prescale 4, PRESET=3: irq on edge 14.
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 14; k++) begin
      tick_n(1);
      chk($sformatf("prescale_irq_e%0d", k), {31'd0, irq}, {31'd0, (k == 14)});
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
